// File: rtl/weight_update_ctrl.sv
// -----------------------------------------------------------------------------
// weight_update_ctrl
//   Read-modify-write sequencer for the N-wide weight RAM. One request updates
//   i_len consecutive N-word windows starting at i_base: for each window it
//   accepts one delta vector, reads the window, adds the deltas with signed
//   saturation and writes the window back. Requests that would run past the
//   last valid word (or have i_len == 0) are rejected without touching the RAM.
//
// Ports
//   i_clk          clock, all state changes on the rising edge
//   i_rst          synchronous reset, active-high
//   i_start        request strobe, only looked at while idle
//   i_base         first word address of window 0
//   i_len          number of windows, 1..7 (0 is rejected)
//   i_delta_valid  i_delta is valid
//   o_delta_ready  controller accepts i_delta (transfer on valid & ready)
//   i_delta        N signed W-bit increments, element i at [i*W +: W]
//   o_busy         high in every state except idle
//   o_done         one-cycle pulse at the end of a request
//   o_err          qualifies o_done: request rejected, RAM untouched
//   o_ram_addr     RAM window address
//   o_ram_we       1 = write o_ram_d, 0 = read
//   o_ram_d        write data, N words
//   i_ram_q        read data, registered by the RAM one clock after address
// -----------------------------------------------------------------------------
module weight_update_ctrl #(
  parameter int N     = 10,
  parameter int W     = 10,
  parameter int AW    = 7,
  parameter int DEPTH = 65
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [AW-1:0]     i_base,
  input  logic [2:0]        i_len,
  input  logic              i_delta_valid,
  output logic              o_delta_ready,
  input  logic [N*W-1:0]    i_delta,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [AW-1:0]     o_ram_addr,
  output logic              o_ram_we,
  output logic [N*W-1:0]    o_ram_d,
  input  logic [N*W-1:0]    i_ram_q
);

  // Bounds arithmetic width: wide enough that base + 7*N never wraps.
  localparam int EW = AW + 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELTA,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [AW-1:0]      r_addr;
  logic [2:0]         r_len;
  logic [2:0]         r_win;
  logic               r_err;
  logic [N*W-1:0]     r_delta;
  logic [N*W-1:0]     r_ram_d;

  logic [EW-1:0]      w_end;
  logic               w_reject;
  logic               w_last_win;
  logic [N*W-1:0]     w_sum;

  // Signed add in W+1 bits; the two top bits of the sum differ exactly when
  // the true result does not fit in W bits, and the top bit gives the sign.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1])
      sat_add = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      sat_add = s[W-1:0];
  endfunction

  assign w_end      = {{(EW-AW){1'b0}}, i_base} + ({{(EW-3){1'b0}}, i_len} * EW'(N));
  assign w_reject   = (i_len == 3'd0) || (w_end > EW'(DEPTH));
  assign w_last_win = (r_win == r_len - 3'd1);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_sum = '0;
    for (int i = 0; i < N; i++)
      w_sum[i*W +: W] = sat_add(i_ram_q[i*W +: W], r_delta[i*W +: W]);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = w_reject ? S_DONE : S_DELTA;
      S_DELTA: if (i_delta_valid) w_next = S_READ;
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = S_WRITE;
      S_WRITE: w_next = w_last_win ? S_DONE : S_DELTA;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_win   <= '0;
      r_err   <= 1'b0;
      r_delta <= '0;
      r_ram_d <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr <= i_base;
            r_len  <= i_len;
            r_win  <= '0;
            r_err  <= w_reject;
          end
        end
        S_DELTA: if (i_delta_valid) r_delta <= i_delta;
        // RAM data is valid during WAIT; the saturated sum is registered so
        // the write data is stable for the whole WRITE cycle.
        S_WAIT:  r_ram_d <= w_sum;
        S_WRITE: begin
          if (!w_last_win) begin
            r_win  <= r_win + 3'd1;
            r_addr <= r_addr + AW'(N);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_err         = (r_state == S_DONE) && r_err;
  assign o_delta_ready = (r_state == S_DELTA);
  // Reset gates the write strobe directly so a reset landing in WRITE
  // never commits the window.
  assign o_ram_we      = (r_state == S_WRITE) && !i_rst;
  assign o_ram_addr    = r_addr;
  assign o_ram_d       = r_ram_d;

endmodule
